// File: rtl/usb_tx_sched_pkg.sv
// Shared widths, state codes and logic levels for the USB TX scheduler.
package usb_tx_sched_pkg;

   localparam int USB_DATA_NBIT = 16;
   localparam int USB_ADDR_NBIT = 8;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;

   // SOP is held for three cycles to cover the sop synchroniser in usb_slavefifo
   localparam logic [1:0] SOP_LAST = 2'd2;

   typedef enum logic [2:0] {
      SCH_IDLE   = 3'd0,
      SCH_SOP    = 3'd1,
      SCH_WSTART = 3'd2,
      SCH_BUSY   = 3'd3,
      SCH_DONE   = 3'd4
   } sch_state_t;

endpackage

// File: rtl/usb_tx_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester above the last owner, wrapping.
module rr_arbiter
   import usb_tx_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last,
   output logic [N-1:0] grant
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] hi_mask;
   logic [N-1:0] req_hi;
   logic [N-1:0] pick;

   // Prefer requesters strictly above the last owner, else wrap to the lowest one
   always_comb begin
      hi_mask = ~(last | (last - ONE));
      req_hi  = req & hi_mask;
      pick    = (req_hi != '0) ? req_hi : req;
      grant   = pick & (~pick + ONE);
   end

endmodule

// File: rtl/usb_tx_sched.sv
// Schedules packets from several requesters onto the single usb_slavefifo TX cache path.
module usb_tx_sched
   import usb_tx_sched_pkg::*;
#(
   parameter int         NREQ      = 4,
   parameter logic [7:0] START_TMO = 8'd255
) (
   input  logic                            ifclk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic [NREQ-1:0]                 req,
   input  logic [NREQ*USB_DATA_NBIT-1:0]   req_data,
   output logic [USB_ADDR_NBIT-1:0]        req_addr,
   output logic                            tx_cache_sop,
   input  logic [USB_ADDR_NBIT-1:0]        tx_cache_addr,
   input  logic                            tx_cache_eop,
   output logic [USB_DATA_NBIT-1:0]        tx_cache_data,
   output logic [NREQ-1:0]                 grant,
   output logic [NREQ-1:0]                 done,
   output logic                            busy,
   output logic                            err_tmo,
   input  logic                            err_clr
);

   localparam logic [NREQ-1:0] LAST_RST = {1'b1, {(NREQ-1){1'b0}}};
   localparam logic [7:0]      TMO_LAST = START_TMO - 8'd1;

   sch_state_t      state, state_nx;
   logic [NREQ-1:0] grant_nx;
   logic [NREQ-1:0] last_grant, last_nx;
   logic [NREQ-1:0] arb_grant;
   logic [1:0]      sop_cnt, sop_cnt_nx;
   logic [7:0]      tmo_cnt, tmo_cnt_nx;
   logic            tmo_hit;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (req),
      .last  (last_grant),
      .grant (arb_grant)
   );

   // State, ownership and counters; reset drops any transfer in flight without a done pulse
   always_ff @(posedge ifclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SCH_IDLE;
         grant      <= '0;
         last_grant <= LAST_RST;
         sop_cnt    <= '0;
         tmo_cnt    <= '0;
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         last_grant <= last_nx;
         sop_cnt    <= sop_cnt_nx;
         tmo_cnt    <= tmo_cnt_nx;
      end
   end

   // Sticky start-timeout flag; a new timeout beats a simultaneous clear
   always_ff @(posedge ifclk or negedge rst_n) begin
      if (!rst_n) begin
         err_tmo <= LOW;
      end else if (tmo_hit) begin
         err_tmo <= HIGH;
      end else if (err_clr) begin
         err_tmo <= LOW;
      end
   end

   // Next-state logic and FSM-driven outputs
   always_comb begin
      state_nx     = state;
      grant_nx     = grant;
      last_nx      = last_grant;
      sop_cnt_nx   = sop_cnt;
      tmo_cnt_nx   = tmo_cnt;
      tmo_hit      = LOW;
      tx_cache_sop = LOW;
      done         = '0;
      busy         = HIGH;
      case (state)
         SCH_IDLE: begin
            busy     = LOW;
            grant_nx = '0;
            // eop low here means someone else's packet is in flight
            if (en && tx_cache_eop && (req != '0)) begin
               grant_nx   = arb_grant;
               sop_cnt_nx = SOP_LAST;
               tmo_cnt_nx = '0;
               state_nx   = SCH_SOP;
            end
         end
         SCH_SOP: begin
            tx_cache_sop = HIGH;
            tmo_cnt_nx   = tmo_cnt + 8'd1;
            if (sop_cnt == 2'd0) begin
               state_nx = SCH_WSTART;
            end else begin
               sop_cnt_nx = sop_cnt - 2'd1;
            end
         end
         SCH_WSTART: begin
            if (!tx_cache_eop) begin
               state_nx = SCH_BUSY;
            end else if (tmo_cnt == TMO_LAST) begin
               // Abandon the packet: no done pulse and the round-robin pointer stays put
               tmo_hit  = HIGH;
               grant_nx = '0;
               state_nx = SCH_IDLE;
            end else begin
               tmo_cnt_nx = tmo_cnt + 8'd1;
            end
         end
         SCH_BUSY: begin
            if (tx_cache_eop) begin
               state_nx = SCH_DONE;
            end
         end
         SCH_DONE: begin
            done     = grant;
            last_nx  = grant;
            grant_nx = '0;
            state_nx = SCH_IDLE;
         end
         default: begin
            grant_nx = '0;
            state_nx = SCH_IDLE;
         end
      endcase
   end

   assign req_addr = tx_cache_addr;

   logic [USB_DATA_NBIT-1:0] data_acc [NREQ+1];

   assign data_acc[0] = '0;

   // OR-chain of gated requester data; zero when nothing is granted
   for (genvar g = 0; g < NREQ; g++) begin : g_mux
      assign data_acc[g+1] = data_acc[g] |
         (grant[g] ? req_data[g*USB_DATA_NBIT +: USB_DATA_NBIT] : '0);
   end

   assign tx_cache_data = data_acc[NREQ];

endmodule

// File: tb/tb_usb_tx_sched.sv
// Bench for usb_tx_sched: requester RAM models, a usb_slavefifo model and a done scoreboard.
module tb_usb_tx_sched;
   import usb_tx_sched_pkg::*;

   localparam int NREQ   = 4;
   localparam int W      = USB_DATA_NBIT;
   localparam int A      = USB_ADDR_NBIT;
   localparam int NWORDS = 1 << A;

   logic                 ifclk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 en = 1'b0;
   logic                 err_clr = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*W-1:0]    req_data;
   logic [A-1:0]         req_addr;
   logic [A-1:0]         tx_cache_addr = '0;
   logic                 tx_cache_sop;
   logic                 tx_cache_eop = 1'b1;
   logic [W-1:0]         tx_cache_data;
   logic [NREQ-1:0]      grant;
   logic [NREQ-1:0]      done;
   logic                 busy;
   logic                 err_tmo;

   int                   n_tests = 0;
   int                   n_fail  = 0;
   int                   n_done  = 0;
   logic [NREQ-1:0]      exp_q [$];
   logic [NREQ-1:0]      mon_exp;
   logic [NREQ-1:0]      done_prev = '0;
   bit                   fifo_on = 1'b0;
   bit                   foreign = 1'b0;

   logic [W-1:0] base [NREQ] = '{16'h1000, 16'h2000, 16'hA5A5, 16'h4000};
   logic [W-1:0] ram_q [NREQ];

   usb_tx_sched #(.NREQ(NREQ), .START_TMO(8'd255)) dut (
      .ifclk         (ifclk),
      .rst_n         (rst_n),
      .en            (en),
      .req           (req),
      .req_data      (req_data),
      .req_addr      (req_addr),
      .tx_cache_sop  (tx_cache_sop),
      .tx_cache_addr (tx_cache_addr),
      .tx_cache_eop  (tx_cache_eop),
      .tx_cache_data (tx_cache_data),
      .grant         (grant),
      .done          (done),
      .busy          (busy),
      .err_tmo       (err_tmo),
      .err_clr       (err_clr)
   );

   always #5 ifclk = ~ifclk;

   // Requester buffers: registered RAM, word = base + address
   for (genvar g = 0; g < NREQ; g++) begin : g_ram
      always @(posedge ifclk) ram_q[g] <= base[g] + {{(W-A){1'b0}}, req_addr};
      assign req_data[g*W +: W] = ram_q[g];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge ifclk);
      #1;
   endtask

   task automatic wait_done(input int target, input int budget);
      int c;
      c = 0;
      while (n_done < target && c < budget) begin
         tick();
         c++;
      end
      chk("wait_done", n_done, target);
   endtask

   task automatic wait_grant(input int budget);
      int c;
      c = 0;
      while (grant == '0 && c < budget) begin
         tick();
         c++;
      end
      chk("wait_grant", 32'(grant != '0), 1);
   endtask

   // Done scoreboard: each pulse pops the expected owner and must last one cycle
   always @(negedge ifclk) begin
      if (rst_n) begin
         if (done_prev != '0) chk("done_1cyc", done, 0);
         if (done != '0) begin
            if (exp_q.size() == 0) begin
               chk("done_unexp", done, 0);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("done", done, mon_exp);
            end
            n_done++;
         end
      end
      done_prev <= done;
   end

   // usb_slavefifo model: sees sop, drops eop, walks all addresses, raises eop
   initial begin : slavefifo
      logic [NREQ-1:0] g;
      logic [W-1:0]    gbase;
      int              n;
      forever begin
         @(negedge ifclk);
         if (fifo_on && rst_n && tx_cache_sop) begin
            if (exp_q.size() == 0) begin
               chk("sop_unexp", exp_q.size(), 1);
               g = '0;
            end else begin
               g = exp_q[0];
            end
            chk("grant_at_sop", grant, g);
            gbase = '0;
            for (int i = 0; i < NREQ; i++) if (g[i]) gbase = base[i];
            n = 1;
            while (n < 8) begin
               @(negedge ifclk);
               if (tx_cache_sop) n++;
               else break;
            end
            chk("sop_len", n, 3);
            @(posedge ifclk);
            #1;
            tx_cache_eop  = 1'b0;
            tx_cache_addr = '0;
            for (int a = 0; a < NWORDS; a++) begin
               @(posedge ifclk);
               #1;
               if (a < NWORDS - 1) tx_cache_addr = A'(a + 1);
               @(negedge ifclk);
               if (!rst_n) break;
               chk("data", tx_cache_data, gbase + W'(a));
            end
            @(posedge ifclk);
            #1;
            tx_cache_eop  = 1'b1;
            tx_cache_addr = '0;
         end else begin
            tx_cache_eop = !foreign;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int seen;
      int c;

      // Reset values
      repeat (3) tick();
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_sop", tx_cache_sop, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_tmo, 0);
      chk("rst_data", tx_cache_data, 0);
      rst_n   = 1'b1;
      en      = 1'b1;
      fifo_on = 1'b1;
      tick();

      // Single packet from requester 0; req dropped once granted
      exp_q.push_back(4'b0001);
      req = 4'b0001;
      tick();
      chk("t1_grant", grant, 4'b0001);
      chk("t1_sop", tx_cache_sop, 1);
      chk("t1_busy", busy, 1);
      req = '0;
      wait_done(1, 400);
      chk("t1_busy_fall", busy, 0);
      chk("t1_grant_clr", grant, 0);

      // Fresh reset, then all four requesting: rotation wraps back to 0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0001);
      req = 4'b1111;
      wait_done(5, 1400);
      wait_grant(10);
      req = '0;
      wait_done(6, 400);
      chk("t2_idle", busy, 0);

      // en low blocks grants; en falling mid-transfer does not abort
      en   = 1'b0;
      req  = 4'b0001;
      seen = 0;
      repeat (100) begin
         tick();
         if (grant != '0) seen++;
      end
      chk("t3_en_block", seen, 0);
      exp_q.push_back(4'b0001);
      en = 1'b1;
      tick();
      chk("t3_grant_next", grant, 4'b0001);
      req = '0;
      en  = 1'b0;
      wait_done(7, 400);
      chk("t3_idle", busy, 0);
      en = 1'b1;

      // Foreign transfer in flight: no grant while eop is low
      fifo_on = 1'b0;
      foreign = 1'b1;
      tick();
      tick();
      req  = 4'b0010;
      seen = 0;
      repeat (20) begin
         tick();
         if (grant != '0) seen++;
      end
      chk("t4_foreign", seen, 0);
      exp_q.push_back(4'b0010);
      foreign = 1'b0;
      fifo_on = 1'b1;
      wait_grant(10);
      req = '0;
      wait_done(8, 400);

      // Start timeout: nobody answers the SOP
      fifo_on = 1'b0;
      req     = 4'b0100;
      wait_grant(10);
      req = '0;
      c   = 0;
      while (!err_tmo && c < 400) begin
         tick();
         c++;
      end
      chk("t5_err", err_tmo, 1);
      chk("t5_cycles", c, 255);
      chk("t5_grant", grant, 0);
      chk("t5_busy", busy, 0);
      repeat (5) tick();
      chk("t5_sticky", err_tmo, 1);
      chk("t5_no_done", n_done, 8);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t5_clr", err_tmo, 0);

      // Round-robin pointer untouched by the timeout: index 2 still wins over 1
      fifo_on = 1'b1;
      exp_q.push_back(4'b0100);
      req = 4'b0110;
      wait_grant(10);
      req = '0;
      wait_done(9, 400);

      // Asynchronous reset in the middle of a packet
      exp_q.push_back(4'b1000);
      req = 4'b1000;
      wait_grant(10);
      req = '0;
      c   = 0;
      while (tx_cache_eop && c < 20) begin
         tick();
         c++;
      end
      chk("t6_in_busy", tx_cache_eop, 0);
      repeat (10) tick();
      @(negedge ifclk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_grant_async", grant, 0);
      chk("t6_sop_async", tx_cache_sop, 0);
      chk("t6_busy_async", busy, 0);
      chk("t6_done_async", done, 0);
      exp_q.delete();
      repeat (3) tick();
      c = 0;
      while (!tx_cache_eop && c < 20) begin
         tick();
         c++;
      end
      chk("t6_eop_back", tx_cache_eop, 1);
      rst_n = 1'b1;
      tick();
      chk("t6_post_rst", busy, 0);
      exp_q.push_back(4'b0010);
      req = 4'b0010;
      wait_grant(10);
      chk("t6_grant", grant, 4'b0010);
      req = '0;
      wait_done(10, 400);
      chk("t6_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
